// File: rtl/trap_pkg.sv
// Shared types and helpers for the trap/exception sequencer.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_VEC,
    ST_LOAD,
    ST_RET,
    ST_HALT
  } trap_state_t;

  // Byte address of a vector table entry: one 32-bit word per cause, wrapping at 32 bits.
  function automatic logic [31:0] vec_entry_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority encoder: the lowest asserted request index wins.
module trap_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates trap requests, saves PC/cause, fetches the
// handler address from the vector table, and handles mret and double faults.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter int          NUM_CAUSES = 4,
  parameter int          CAUSE_W    = $clog2(NUM_CAUSES),
  parameter logic [31:0] VEC_BASE   = 32'd254,
  parameter int          MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CAUSES-1:0] trap_req,
  input  logic                  trap_en,
  input  logic                  mret_req,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [31:0]           imem_rdata,
  output logic                  imem_sel,
  output logic [31:0]           imem_addr,
  output logic [XLEN-1:0]       pc_next,
  output logic                  pc_load,
  output logic [NUM_CAUSES-1:0] trap_ack,
  output logic [XLEN-1:0]       epc,
  output logic [CAUSE_W-1:0]    cause,
  output logic                  in_handler,
  output logic                  busy,
  output logic                  halted
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  trap_state_t          state_q, state_d;
  logic [XLEN-1:0]      epc_q, epc_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic [CAUSE_W-1:0]   idx_q, idx_d;
  logic                 in_handler_q, in_handler_d;
  logic                 halted_q, halted_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [CAUSE_W-1:0]   req_idx;
  logic                 req_vld;
  logic                 trap_take;

  trap_prio_enc #(
    .N(NUM_CAUSES),
    .W(CAUSE_W)
  ) u_prio (
    .req_i(trap_req),
    .idx_o(req_idx),
    .vld_o(req_vld)
  );

  assign trap_take = trap_en & req_vld;

  // State and architectural registers; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      idx_q        <= '0;
      in_handler_q <= 1'b0;
      halted_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      idx_q        <= idx_d;
      in_handler_q <= in_handler_d;
      halted_q     <= halted_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and output decode; the winning index is latched in IDLE so a
  // requester dropping its line early cannot change the saved cause.
  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    idx_d        = idx_q;
    in_handler_d = in_handler_q;
    halted_d     = halted_q;
    cnt_d        = cnt_q;
    imem_sel     = 1'b0;
    imem_addr    = '0;
    pc_next      = '0;
    pc_load      = 1'b0;
    trap_ack     = '0;

    case (state_q)
      ST_IDLE: begin
        if (trap_take) begin
          idx_d   = req_idx;
          state_d = ST_SAVE;
        end else if (mret_req && in_handler_q) begin
          state_d = ST_RET;
        end
      end
      ST_SAVE: begin
        if (in_handler_q) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          epc_d        = pc_in;
          cause_d      = idx_q;
          in_handler_d = 1'b1;
          trap_ack     = NUM_CAUSES'(1) << idx_q;
          cnt_d        = '0;
          state_d      = ST_VEC;
        end
      end
      ST_VEC: begin
        imem_sel  = 1'b1;
        imem_addr = vec_entry_addr(VEC_BASE, 32'(cause_q));
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        imem_sel  = 1'b1;
        imem_addr = vec_entry_addr(VEC_BASE, 32'(cause_q));
        pc_next   = XLEN'(imem_rdata);
        pc_load   = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_RET: begin
        pc_next      = epc_q;
        pc_load      = 1'b1;
        in_handler_d = 1'b0;
        state_d      = ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign epc        = epc_q;
  assign cause      = cause_q;
  assign in_handler = in_handler_q;
  assign halted     = halted_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: random trap/mret/mask/reset transactions,
// expectations derived from the sequencing rules, checked by a monitor.
module tb_trap_ctrl;

  localparam int          XLEN     = 64;
  localparam int          NC       = 4;
  localparam int          CW       = 2;
  localparam logic [31:0] VEC_BASE = 32'd254;
  localparam int          MEM_LAT  = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NC-1:0]   trap_req = '0;
  logic            trap_en = 1'b1;
  logic            mret_req = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic [31:0]     imem_rdata = '0;
  logic            imem_sel;
  logic [31:0]     imem_addr;
  logic [XLEN-1:0] pc_next;
  logic            pc_load;
  logic [NC-1:0]   trap_ack;
  logic [XLEN-1:0] epc;
  logic [CW-1:0]   cause;
  logic            in_handler;
  logic            busy;
  logic            halted;

  trap_ctrl #(
    .XLEN(XLEN), .NUM_CAUSES(NC), .CAUSE_W(CW), .VEC_BASE(VEC_BASE), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .trap_req(trap_req), .trap_en(trap_en),
    .mret_req(mret_req), .pc_in(pc_in), .imem_rdata(imem_rdata),
    .imem_sel(imem_sel), .imem_addr(imem_addr), .pc_next(pc_next),
    .pc_load(pc_load), .trap_ack(trap_ack), .epc(epc), .cause(cause),
    .in_handler(in_handler), .busy(busy), .halted(halted)
  );

  typedef struct {
    int          kind;   // 0 = trap_ack pulse, 1 = pc_load
    int          cyc;
    logic [63:0] val;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;

  // Reference state: what the architecture should hold between transactions.
  bit          m_inh = 1'b0;
  logic [63:0] m_epc = '0;
  int          m_cause = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd262) return 32'h0000_0200;
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_sel) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack or PC write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && (pc_load || trap_ack != '0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: pc_load=%0b trap_ack=%b pc_next=0x%0h expected none (cycle %0d)",
                 pc_load, trap_ack, pc_next, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_cycle", 64'(cyc), 64'(mon_e.cyc));
        if (mon_e.kind == 0) begin
          chk("trap_ack", 64'(trap_ack), mon_e.val);
          chk("ack_no_load", 64'(pc_load), 64'd0);
        end else begin
          chk("pc_load", 64'(pc_load), 64'd1);
          chk("pc_next", pc_next, mon_e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [NC-1:0] r);
    for (int i = 0; i < NC; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic push_ev(input int kind, input int c, input logic [63:0] v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pc_load"}, 64'(pc_load), 0);
    chk({tag, "_trap_ack"}, 64'(trap_ack), 0);
    chk({tag, "_imem_sel"}, 64'(imem_sel), 0);
    chk({tag, "_imem_addr"}, 64'(imem_addr), 0);
    chk({tag, "_pc_next"}, pc_next, 0);
    chk({tag, "_epc"}, epc, 0);
    chk({tag, "_cause"}, 64'(cause), 0);
    chk({tag, "_in_handler"}, 64'(in_handler), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_halted"}, 64'(halted), 0);
  endtask

  task automatic do_reset(input int n, input logic [NC-1:0] req);
    reset    = 1'b1;
    trap_req = req;
    mret_req = 1'b0;
    trap_en  = 1'b1;
    step();
    mon_en = 1'b1;
    repeat (n - 1) step();
    reset    = 1'b0;
    trap_req = '0;
    m_inh    = 1'b0;
    m_epc    = '0;
    m_cause  = 0;
    exp_q.delete();
    check_all_zero("reset");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(n >= 50), 0);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_epc"}, epc, m_epc);
    chk({tag, "_cause"}, 64'(cause), 64'(m_cause));
    chk({tag, "_in_handler"}, 64'(in_handler), 64'(m_inh));
    chk({tag, "_halted"}, 64'(halted), 0);
  endtask

  task automatic check_halted_then_reset();
    chk("halt_halted", 64'(halted), 1);
    chk("halt_busy", 64'(busy), 1);
    chk("halt_drained", 64'(exp_q.size()), 0);
    trap_req = 4'($urandom_range(1, 15));
    mret_req = 1'b1;
    pc_in    = {$urandom, $urandom};
    repeat (3) step();
    mret_req = 1'b0;
    trap_req = '0;
    chk("halt_sticky", 64'(halted), 1);
    chk("halt_epc_kept", epc, m_epc);
    chk("halt_cause_kept", 64'(cause), 64'(m_cause));
    do_reset(2, '0);
  endtask

  task automatic trap_txn(input logic [NC-1:0] req, input logic [63:0] pc,
                          input bit with_mret, input bit keep_pending, input bit mid_reset);
    int            t;
    int            idx;
    logic [NC-1:0] rest;
    idx      = lowest(req);
    t        = cyc;
    trap_en  = 1'b1;
    trap_req = req;
    pc_in    = pc;
    mret_req = with_mret;
    if (m_inh) begin
      // Trap taken while already in a handler: double fault, no ack, no PC write.
      step();
      trap_req = '0;
      mret_req = 1'b0;
      repeat (3) step();
      check_halted_then_reset();
      return;
    end
    push_ev(0, t + 1, 64'(4'b0001 << idx));
    if (!mid_reset) push_ev(1, t + 2 + MEM_LAT, 64'(mem_word(VEC_BASE + 32'(4 * idx))));
    step();
    mret_req = 1'b0;
    rest     = req & ~(4'b0001 << idx);
    trap_req = keep_pending ? rest : '0;
    m_epc    = pc;
    m_cause  = idx;
    m_inh    = 1'b1;
    step();
    chk("vec_imem_sel", 64'(imem_sel), 1);
    chk("vec_imem_addr", 64'(imem_addr), 64'(VEC_BASE + 32'(4 * idx)));
    if (mid_reset) begin
      do_reset(1, '0);
      repeat (3) step();
      check_regs("after_mid_reset");
      return;
    end
    if (keep_pending && rest != '0) begin
      // Pending line is re-arbitrated once back in IDLE; an mret in that
      // same cycle must lose, and the second trap double-faults.
      repeat (MEM_LAT + 1) step();
      mret_req = 1'b1;
      step();
      mret_req = 1'b0;
      repeat (3) step();
      check_halted_then_reset();
      return;
    end
    wait_idle();
    check_regs("trap");
  endtask

  task automatic mret_txn();
    int t;
    t        = cyc;
    trap_req = '0;
    mret_req = 1'b1;
    if (m_inh) begin
      push_ev(1, t + 1, m_epc);
      m_inh = 1'b0;
    end
    step();
    mret_req = 1'b0;
    repeat (2) step();
    wait_idle();
    check_regs("mret");
  endtask

  task automatic masked_txn(input logic [NC-1:0] req);
    trap_en  = 1'b0;
    trap_req = req;
    repeat (4) step();
    chk("masked_busy", 64'(busy), 0);
    trap_req = '0;
    trap_en  = 1'b1;
    step();
    check_regs("masked");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [NC-1:0] rq;
    step();
    do_reset(2, 4'b0010);
    repeat (2) step();
    check_regs("post_reset");

    trap_txn(4'b0100, 64'h40, 1'b0, 1'b0, 1'b0);
    chk("t2_epc", epc, 64'h40);
    chk("t2_cause", 64'(cause), 2);
    mret_txn();
    masked_txn(4'b0001);
    mret_txn();
    trap_txn(4'b1010, 64'h80, 1'b0, 1'b1, 1'b0);
    trap_txn(4'b0001, 64'h1234, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 150; k++) begin
      r  = $urandom_range(0, 9);
      rq = 4'($urandom_range(1, 15));
      if (r <= 3 || r == 9)
        trap_txn(rq, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), 1'b0);
      else if (r <= 6)
        mret_txn();
      else if (r == 7)
        masked_txn(rq);
      else
        trap_txn(rq, {$urandom, $urandom}, 1'b0, 1'b0, !m_inh);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
